// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C write arbiter
package i2c_arb_pkg;

    localparam int ADDR_W            = 7;
    localparam int DATA_W            = 8;
    localparam int DEF_START_TIMEOUT = 16;
    localparam int DEF_XFER_TIMEOUT  = 2000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_COMPLETE
    } arb_state_t;

    // Watchdog counter width: large enough to hold (larger timeout - 1).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick returning a one-hot grant
module rr_priority_select #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid
);

    logic [PW:0] w_idx;

    // Scan upward from the pointer, wrapping at N; first set request wins.
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!o_valid && i_req[w_idx[PW-1:0]]) begin
                o_gnt[w_idx[PW-1:0]] = 1'b1;
                o_valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_write_arbiter.sv
// rtl/i2c_write_arbiter.sv - round-robin sharing of one I2C master writer; optional I2C_ARB_LOCK_EN
module i2c_write_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT  = DEF_XFER_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
`ifdef I2C_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      m_start,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_data,
    input  logic                      m_busy,
    input  logic                      m_done,
    output logic                      arb_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(START_TIMEOUT, XFER_TIMEOUT);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_err, w_err_nxt;
    logic               r_start, w_start_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;

    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_sel_ptr;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic               w_rr_valid;
    logic [NUM_REQ-1:0] w_pick;
    logic               w_pick_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_priority_select #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (w_sel_ptr),
        .o_gnt   (w_rr_gnt),
        .o_valid (w_rr_valid)
    );

`ifdef I2C_ARB_LOCK_EN
    logic               r_hold, w_hold_nxt;
    logic [NUM_REQ-1:0] w_self;
    logic               w_hold_hit;

    // A locked owner that is still requesting keeps the bus; otherwise rotate past it.
    assign w_self       = NUM_REQ'(1) << r_ptr;
    assign w_hold_hit   = r_hold && |(req_valid & w_self);
    assign w_sel_ptr    = r_hold ? ptr_inc(r_ptr) : r_ptr;
    assign w_pick       = w_hold_hit ? w_self : w_rr_gnt;
    assign w_pick_valid = w_hold_hit | w_rr_valid;
`else
    assign w_sel_ptr    = r_ptr;
    assign w_pick       = w_rr_gnt;
    assign w_pick_valid = w_rr_valid;
`endif

    // Index of the current owner, used to rotate the pointer past it.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx = PTR_W'(i);
            end
        end
    end

    // Next-state and datapath decisions for one transaction on the master.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_start_nxt = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
`ifdef I2C_ARB_LOCK_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            S_IDLE: begin
                // A master still winding down a previous byte must go idle first.
                if (!m_busy && w_pick_valid) begin
                    w_grant_nxt = w_pick;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (w_pick[i]) begin
                            w_addr_nxt = req_addr[ADDR_W*i +: ADDR_W];
                            w_data_nxt = req_data[DATA_W*i +: DATA_W];
                        end
                    end
`ifdef I2C_ARB_LOCK_EN
                    w_hold_nxt  = 1'b0;
`endif
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // A done seen here (even with busy) means the byte already went out.
                // The start-pulse cycle itself is not charged against the budget.
                if (m_done) begin
                    w_state_nxt = S_COMPLETE;
                end else if (m_busy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT_DONE;
                end else if (!r_start) begin
                    if (r_cnt == START_LAST) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_COMPLETE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (m_done) begin
                    w_state_nxt = S_COMPLETE;
                end else if (r_cnt == XFER_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_COMPLETE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_COMPLETE: begin
                w_grant_nxt = '0;
                w_err_nxt   = 1'b0;
                w_ptr_nxt   = ptr_inc(w_gidx);
`ifdef I2C_ARB_LOCK_EN
                if (|(req_lock & r_grant)) begin
                    w_ptr_nxt  = w_gidx;
                    w_hold_nxt = 1'b1;
                end
`endif
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
`ifdef I2C_ARB_LOCK_EN
            r_hold  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_start <= w_start_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
`ifdef I2C_ARB_LOCK_EN
            r_hold  <= w_hold_nxt;
`endif
        end
    end

    assign grant    = r_grant;
    assign m_start  = r_start;
    assign m_addr   = r_addr;
    assign m_data   = r_data;
    assign arb_busy = (r_state != S_IDLE);
    assign req_done = (r_state == S_COMPLETE) ? r_grant : '0;
    assign req_err  = (r_state == S_COMPLETE && r_err) ? r_grant : '0;

endmodule

// File: doc/i2c_write_arbiter.md
Name: i2c_write_arbiter

Overview:
- Shares the single I2C master writer between several byte-write requesters: the LCD controller and future audio-processor and volume-IC config writers.
- Round-robin arbitration with a per-requester hold-until-done handshake.
- Sequences each transaction on the master: start pulse, busy-rise check, done wait.
- Per-transaction watchdog so a hung master or bus never deadlocks the requesters.

Parameters:
- NUM_REQ, 2, number of requesters (2..8); index 0 = LCD controller.
- START_TIMEOUT, 16, clk cycles allowed from m_start to m_busy high.
- XFER_TIMEOUT, 2000, clk cycles allowed from m_busy high to m_done.

Ports:
- clk  in  1  clock; same clock domain as the I2C master writer (1 MHz).
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's req_done.
- req_addr  in  7*NUM_REQ  packed 7-bit slave addresses; requester i at [7i+6:7i].
- req_data  in  8*NUM_REQ  packed data bytes; requester i at [8i+7:8i].
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  NUM_REQ  one-cycle error flag, coincident with req_done, on timeout.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- m_start  out  1  one-cycle start pulse to the master.
- m_addr  out  7  latched slave address.
- m_data  out  8  latched data byte.
- m_busy  in  1  master busy.
- m_done  in  1  master done pulse.
- arb_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0; counters 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Set grant one-hot, latch m_addr/m_data from that slice, go to ISSUE.
  - If m_busy is high in IDLE (master still finishing), wait; do not grant.
- ISSUE: m_start = 1 for exactly one cycle; clear counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - m_busy = 1: clear counter, go to WAIT_DONE.
  - Else if counter reaches START_TIMEOUT-1: set error, go to COMPLETE.
  - If m_done and m_busy arrive in the same cycle, treat it as done: go to COMPLETE without error.
- WAIT_DONE:
  - m_done = 1: go to COMPLETE.
  - Else if counter reaches XFER_TIMEOUT-1: set error, go to COMPLETE.
- COMPLETE:
  - req_done[g] = 1 for one cycle; req_err[g] = error flag.
  - Pointer = (g+1) mod NUM_REQ.
  - Clear grant and error flag; go to IDLE.
- Latency: grant appears the cycle after req_valid is sampled in IDLE; m_start 1 cycle after grant. The requester must drop req_valid on the cycle after req_done, or a new transaction follows.
- Minimum 1 IDLE cycle between transactions.
- Simultaneous requests are served in round-robin order: with both 0 and 1 requesting continuously, grants alternate 0,1,0,1.
- req_valid dropping while granted (protocol violation): the transaction completes; req_done still pulses.
- m_addr/m_data are stable from grant until the next grant, independent of req_* changes.
- Counter widths are sized by $clog2 of the larger timeout; no wrap occurs before timeout detection.
- Reset asserted mid-transaction: immediate return to the reset state; m_start never glitches.

Optional Feature:
- I2C_ARB_LOCK_EN adds input req_lock [NUM_REQ].
- Defined: if req_lock[g] is high in COMPLETE and req_valid[g] is high the next cycle, g keeps the grant without rotation. Used for atomic LCD nibble/enable sequences. The pointer advances only when the lock is released.
- Undefined: the port is absent and strict round-robin applies after every byte.

Decomposition:
- Shared package i2c_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE);
  - ADDR_W = 7, DATA_W = 8;
  - default timeout constants.
- One natural sub-module, rr_priority_select: combinational round-robin pick from a request vector and pointer, returning a one-hot grant and a valid flag.

Test Plan:
- Single request: req 0 with addr 0x27, data 0xA5; master busy for 20 cycles then done → m_start one cycle after grant, m_addr = 0x27, m_data = 0xA5, req_done[0] one cycle after m_done, req_err = 0.
- Contention: req 0 and req 1 both held for 4 transactions each → grant order 0,1,0,1,0,1,0,1; no overlapping m_start.
- Busy never rises after m_start → req_done and req_err pulse together exactly START_TIMEOUT+1 cycles after m_start; arbiter returns to IDLE.
- Busy high, no m_done for 2000 cycles → req_err at timeout; next request is served normally.
- Reset pulse in WAIT_DONE → all outputs 0 immediately; a fresh req 1 after release is granted with pointer 0.
- I2C_ARB_LOCK_EN: req 0 holds lock for 3 bytes while req 1 is pending → grants 0,0,0,1.
